read_pointer_handler: RTL and testbench
=======================================

# read_pointer_handler

Read-side pointer and flag logic for the asynchronous FIFO, the counterpart of the write pointer handler. It runs entirely in the read clock domain and advances a binary/Gray read pointer on accepted reads. It compares that pointer against the write pointer, which arrives already synchronized into this domain, to produce registered empty, almost-empty, fill-level and sticky underflow outputs. `read_addr` drives the dual-port RAM read address; `read_ptr` goes to the read-to-write synchronizer.

## Interface
- `ADDR_WIDTH`, 4: RAM address width; FIFO depth is 2^ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
- `ALMOST_EMPTY_THRESH`, 2: `read_almost_empty` asserts when level <= this value; legal range 0..2^ADDR_WIDTH.

Ports:
- `read_clock`  in  1  read-domain clock; all state on rising edge.
- `read_reset_n`  in  1  asynchronous, active-low reset.
- `read_enable`  in  1  read request for this cycle.
- `underflow_clear`  in  1  clears the sticky underflow flag.
- `sync_write_ptr`  in  ADDR_WIDTH+1  Gray write pointer, already synchronized to `read_clock`.
- `read_addr`  out  ADDR_WIDTH  RAM read address, equal to `read_bin[ADDR_WIDTH-1:0]`.
- `read_ptr`  out  ADDR_WIDTH+1  registered Gray read pointer.
- `read_empty`  out  1  registered empty flag.
- `read_almost_empty`  out  1  registered almost-empty flag.
- `read_level`  out  ADDR_WIDTH+1  registered fill level, range 0..2^ADDR_WIDTH.
- `read_underflow`  out  1  sticky flag: a read was attempted while empty.

## Operation
- **Accepted read:** `read_accept = read_enable & ~read_empty`.
- **Next pointer:** `read_bin_next = read_bin + read_accept`, modulo 2^(ADDR_WIDTH+1). `read_gray_next = (read_bin_next >> 1) ^ read_bin_next`.
- **Pointer update:** each edge, `{read_bin, read_ptr} <= {read_bin_next, read_gray_next}`.
- **Empty:** `read_empty <= (read_gray_next == sync_write_ptr)`. The comparison uses the full ADDR_WIDTH+1 bits with no MSB inversion.
- **Write pointer decode:** `sync_write_ptr` is Gray-to-binary decoded combinationally. Bit i is the XOR of bits ADDR_WIDTH..i.
- **Level:** `read_level <= wbin - read_bin_next`, modulo 2^(ADDR_WIDTH+1). A level of 0 must coincide with `read_empty=1` on the same edge.
- **Almost-empty:** `read_almost_empty <= (level_next <= ALMOST_EMPTY_THRESH)`.
- **Underflow:** `read_enable & read_empty` sets `read_underflow` at the next edge; the pointer does not move. `underflow_clear` clears it. If set and clear occur in the same cycle, set wins.
- **Reset values:** `read_bin` = 0, `read_ptr` = 0, `read_addr` = 0, `read_empty` = 1, `read_almost_empty` = 1, `read_level` = 0, `read_underflow` = 0. `read_empty` is set on reset, unlike the write side's full flag, which is cleared.
- **Conservative flags:** the synchronized write pointer lags the true write pointer. `read_empty` and `read_level` may therefore be pessimistic, but must never report data that has not been written.

## Timing
- **Read latency:** a read accepted at edge N moves `read_addr` and `read_ptr` at edge N. The RAM data for the new address is the RAM's concern.
- **Flag timing:** all flags reflect the pointer state after edge N's update, in the same edge. Back-to-back reads drain to empty with no bubble, and the last read asserts `read_empty` at the same edge.
- **Write arrival:** a `sync_write_ptr` change seen before edge N updates `read_empty`, `read_level` and `read_almost_empty` at edge N. That is one read-clock cycle after the synchronizer output changes.
- **Simultaneous read and write arrival:** the level uses `read_bin_next`, so the net change is applied in one edge.
- **Wrap:** the pointer rolls from 2^(ADDR_WIDTH+1)-1 to 0; `read_addr` wraps from 2^ADDR_WIDTH-1 to 0. No special casing is allowed.
- **Reset mid-operation:** asserting `read_reset_n` forces all outputs to their reset values immediately, without waiting for a clock edge. Deassertion is assumed synchronized externally.

## Configuration
- **`READ_LEVEL_EN` defined:** the Gray decode, level subtractor and almost-empty compare are built as described.
- **`READ_LEVEL_EN` undefined:** the Gray decode, level subtractor and almost-empty compare are not built. `read_level` is tied to 0 and `read_almost_empty` is driven identically to `read_empty` (reset value 1). Empty and underflow behaviour is unchanged.

## Test plan
- **Reset:** hold `read_reset_n`=0 with `read_enable`=1 -> `read_empty`=1, `read_almost_empty`=1, `read_ptr`=5'b00000, `read_addr`=0, `read_level`=0, `read_underflow`=0.
- **Fill then drain:** `sync_write_ptr`=5'b00010 (bin 3) -> next edge `read_empty`=0, `read_level`=3, `read_almost_empty`=0. Then three reads -> `read_addr`=1,2,3 and `read_level`=2,1,0; `read_almost_empty`=1 from level 2; `read_empty`=1 on the third edge.
- **Underflow:** `read_enable`=1 while empty -> `read_addr` is unchanged and `read_underflow`=1, holding after `read_enable` drops. `read_enable`=1 and `underflow_clear`=1 in the same cycle -> stays 1. `underflow_clear` alone -> 0.
- **Wrap:** `sync_write_ptr`=5'b11000 (bin 16), then 16 reads -> `read_addr` goes 15->0, `read_ptr`=5'b11000, `read_empty`=1. Then `sync_write_ptr`=5'b11110 (bin 20) -> `read_level`=4, `read_empty`=0.
- **Reset mid-operation:** with `read_level`=5, pulse `read_reset_n` low between edges -> all outputs take reset values before the next edge.
- **Macro off:** build without `READ_LEVEL_EN` and repeat fill-then-drain -> `read_level` stays 0 and `read_almost_empty` tracks `read_empty` exactly.

Source files
------------

// File: rtl/read_pointer_handler.sv
// Read-side pointer, empty/almost-empty/level and sticky underflow logic for an async FIFO.
// Define READ_LEVEL_EN to build the Gray decode, level subtractor and almost-empty compare.
module read_pointer_handler #(
  parameter int ADDR_WIDTH          = 4,
  parameter int ALMOST_EMPTY_THRESH = 2
) (
  input  logic                  read_clock,
  input  logic                  read_reset_n,
  input  logic                  read_enable,
  input  logic                  underflow_clear,
  input  logic [ADDR_WIDTH:0]   sync_write_ptr,
  output logic [ADDR_WIDTH-1:0] read_addr,
  output logic [ADDR_WIDTH:0]   read_ptr,
  output logic                  read_empty,
  output logic                  read_almost_empty,
  output logic [ADDR_WIDTH:0]   read_level,
  output logic                  read_underflow
);

  logic [ADDR_WIDTH:0] read_bin;
  logic [ADDR_WIDTH:0] read_bin_next;
  logic [ADDR_WIDTH:0] read_gray_next;
  logic                read_accept;
  logic                underflow_set;

  assign read_accept    = read_enable & ~read_empty;
  assign underflow_set  = read_enable & read_empty;
  assign read_bin_next  = read_bin + {{ADDR_WIDTH{1'b0}}, read_accept};
  assign read_gray_next = (read_bin_next >> 1) ^ read_bin_next;
  assign read_addr      = read_bin[ADDR_WIDTH-1:0];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge read_clock or negedge read_reset_n) begin
    if (!read_reset_n) begin
      read_bin       <= '0;
      read_ptr       <= '0;
      read_empty     <= 1'b1;
      read_underflow <= 1'b0;
    end else begin
      read_bin       <= read_bin_next;
      read_ptr       <= read_gray_next;
      // Comparing the post-read pointer lets the last read flag empty on its own edge.
      read_empty     <= (read_gray_next == sync_write_ptr);
      read_underflow <= underflow_set | (read_underflow & ~underflow_clear);
    end
  end

`ifdef READ_LEVEL_EN
  localparam logic [ADDR_WIDTH:0] THRESH = ALMOST_EMPTY_THRESH[ADDR_WIDTH:0];

  logic [ADDR_WIDTH:0] write_bin;
  logic [ADDR_WIDTH:0] level_next;

  // NOTE: every always_comb output gets a default before the loop so no latch
  // can be inferred.
  always_comb begin
    write_bin             = '0;
    write_bin[ADDR_WIDTH] = sync_write_ptr[ADDR_WIDTH];
    for (int i = ADDR_WIDTH - 1; i >= 0; i--) begin
      write_bin[i] = write_bin[i+1] ^ sync_write_ptr[i];
    end
  end

  assign level_next = write_bin - read_bin_next;

  always_ff @(posedge read_clock or negedge read_reset_n) begin
    if (!read_reset_n) begin
      read_level        <= '0;
      read_almost_empty <= 1'b1;
    end else begin
      read_level        <= level_next;
      read_almost_empty <= (level_next <= THRESH);
    end
  end
`else
  assign read_level        = '0;
  assign read_almost_empty = read_empty;
`endif

endmodule

// File: tb/tb_read_pointer_handler.sv
// Directed bench for read_pointer_handler: reset, fill/drain, underflow, wrap and async reset.
// Level/almost-empty expectations follow whether READ_LEVEL_EN is defined.
module tb_read_pointer_handler;

  logic       read_clock = 1'b0;
  logic       read_reset_n;
  logic       read_enable;
  logic       underflow_clear;
  logic [4:0] sync_write_ptr;
  logic [3:0] read_addr;
  logic [4:0] read_ptr;
  logic       read_empty;
  logic       read_almost_empty;
  logic [4:0] read_level;
  logic       read_underflow;

  int total = 0;
  int bad   = 0;

  read_pointer_handler #(.ADDR_WIDTH(4), .ALMOST_EMPTY_THRESH(2)) dut (
    .read_clock        (read_clock),
    .read_reset_n      (read_reset_n),
    .read_enable       (read_enable),
    .underflow_clear   (underflow_clear),
    .sync_write_ptr    (sync_write_ptr),
    .read_addr         (read_addr),
    .read_ptr          (read_ptr),
    .read_empty        (read_empty),
    .read_almost_empty (read_almost_empty),
    .read_level        (read_level),
    .read_underflow    (read_underflow)
  );

  always #5 read_clock = ~read_clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge read_clock);
    #1;
  endtask

  function automatic logic [31:0] exp_level(input int lvl);
`ifdef READ_LEVEL_EN
    return lvl;
`else
    return 0;
`endif
  endfunction

  function automatic logic [31:0] exp_ae(input int lvl, input logic empty);
`ifdef READ_LEVEL_EN
    return (lvl <= 2) ? 1 : 0;
`else
    return {31'd0, empty};
`endif
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_empty"}, read_empty, 1);
    check({tag, "_ae"}, read_almost_empty, 1);
    check({tag, "_ptr"}, read_ptr, 0);
    check({tag, "_addr"}, read_addr, 0);
    check({tag, "_level"}, read_level, 0);
    check({tag, "_uf"}, read_underflow, 0);
  endtask

  initial begin
    read_reset_n    = 1'b0;
    read_enable     = 1'b1;
    underflow_clear = 1'b0;
    sync_write_ptr  = 5'b00000;
    repeat (3) tick();
    check_reset_values("reset");

    read_enable  = 1'b0;
    read_reset_n = 1'b1;
    tick();
    check("idle_empty", read_empty, 1);
    check("idle_uf", read_underflow, 0);

    // Fill: write pointer Gray 00010 = binary 3
    sync_write_ptr = 5'b00010;
    tick();
    check("fill_empty", read_empty, 0);
    check("fill_level", read_level, exp_level(3));
    check("fill_ae", read_almost_empty, exp_ae(3, 1'b0));

    read_enable = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check($sformatf("drain%0d_addr", i), read_addr, i);
      check($sformatf("drain%0d_level", i), read_level, exp_level(3 - i));
      check($sformatf("drain%0d_empty", i), read_empty, (i == 3) ? 1 : 0);
      check($sformatf("drain%0d_ae", i), read_almost_empty, exp_ae(3 - i, i == 3));
    end
    read_enable = 1'b0;
    check("drain_ptr", read_ptr, 5'b00010);

    // Underflow
    read_enable = 1'b1;
    tick();
    check("uf_addr_hold", read_addr, 3);
    check("uf_set", read_underflow, 1);
    read_enable = 1'b0;
    tick();
    check("uf_sticky", read_underflow, 1);
    read_enable     = 1'b1;
    underflow_clear = 1'b1;
    tick();
    check("uf_set_wins", read_underflow, 1);
    check("uf_set_wins_addr", read_addr, 3);
    read_enable = 1'b0;
    tick();
    check("uf_cleared", read_underflow, 0);
    underflow_clear = 1'b0;

    // Wrap: write pointer Gray 11000 = binary 16; read from 3 up to 16
    sync_write_ptr = 5'b11000;
    tick();
    check("wrap_fill_empty", read_empty, 0);
    check("wrap_fill_level", read_level, exp_level(13));
    read_enable = 1'b1;
    for (int i = 0; i < 13; i++) begin
      tick();
      check($sformatf("wrap%0d_addr", i), read_addr, (4 + i) % 16);
    end
    read_enable = 1'b0;
    check("wrap_ptr", read_ptr, 5'b11000);
    check("wrap_empty", read_empty, 1);
    check("wrap_level", read_level, 0);

    // Gray 11110 = binary 20
    sync_write_ptr = 5'b11110;
    tick();
    check("post_wrap_level", read_level, exp_level(4));
    check("post_wrap_empty", read_empty, 0);
    check("post_wrap_ae", read_almost_empty, exp_ae(4, 1'b0));

    // Gray 11111 = binary 21
    sync_write_ptr = 5'b11111;
    tick();
    check("pre_rst_level", read_level, exp_level(5));
    check("pre_rst_ptr", read_ptr, 5'b11000);

    // Asynchronous reset pulse between edges
    #2;
    read_reset_n = 1'b0;
    #1;
    check_reset_values("async_rst");
    sync_write_ptr = 5'b00000;
    tick();
    read_reset_n = 1'b1;
    tick();
    check("after_rst_empty", read_empty, 1);
    check("after_rst_addr", read_addr, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
